// File: rtl/ptmch_pkg.sv
// Shared types and widths for the ptmch register-write path.
// ptmch_wr_t is the address/data bundle consumed by the trigger stage.
package ptmch_pkg;

    localparam int unsigned PTMCH_ADDR_W = 8;
    localparam int unsigned PTMCH_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX,
        ST_END
    } spi_rx_st_t;

    typedef struct packed {
        logic [PTMCH_ADDR_W-1:0] addr;
        logic [PTMCH_DATA_W-1:0] data;
    } ptmch_wr_t;

endpackage

// File: rtl/ptmch_sync.sv
// N-stage flip-flop synchroniser for a single asynchronous input.
// Every stage resets to RST_VAL, which is the idle level of the input.
module ptmch_sync #(
    parameter int unsigned N       = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q <= {N{RST_VAL}};
        end else begin
            ff_q <= {ff_q[N-2:0], d_i};
        end
    end

    assign q_o = ff_q[N-1];

endmodule

// File: rtl/ptmch_spi_rx.sv
// SPI mode-0 slave receiver: one ADDR_W+DATA_W frame per chip-select window,
// decoded in the CLK160M domain into a one-cycle register-write strobe.
module ptmch_spi_rx
    import ptmch_pkg::*;
#(
    parameter int unsigned ADDR_W      = PTMCH_ADDR_W,
    parameter int unsigned DATA_W      = PTMCH_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK160M,
    input  logic              RESET,
    input  logic              SPI_CS,
    input  logic              SPI_CLK,
    input  logic              SPI_MOSI,
    output logic              WR_VLD,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              FRM_ERR,
    output logic              BUSY
);

    localparam int unsigned FRAME_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
    localparam int unsigned SET_W   = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [SET_W-1:0] SET_DONE = SET_W'(SYNC_STAGES + 1);

    logic s_cs, s_clk, s_mosi;
    logic s_cs_d_q, s_clk_d_q;
    logic sclk_rise, cs_fall, cs_rise;

    spi_rx_st_t         state_q,   state_d;
    logic [FRAME_W-1:0] shreg_q,   shreg_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [SET_W-1:0]   settle_q,  settle_d;
    logic               armed_q,   armed_d;
    logic               wr_vld_q,  wr_vld_d;
    logic               frm_err_q, frm_err_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    ptmch_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i(CLK160M), .rst_i(RESET), .d_i(SPI_CS), .q_o(s_cs)
    );

    ptmch_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk_i(CLK160M), .rst_i(RESET), .d_i(SPI_CLK), .q_o(s_clk)
    );

    ptmch_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(CLK160M), .rst_i(RESET), .d_i(SPI_MOSI), .q_o(s_mosi)
    );

    assign sclk_rise = s_clk & ~s_clk_d_q;
    assign cs_fall   = ~s_cs & s_cs_d_q;
    assign cs_rise   = s_cs & ~s_cs_d_q;

    always_ff @(posedge CLK160M or posedge RESET) begin
        if (RESET) begin
            s_cs_d_q  <= 1'b1;
            s_clk_d_q <= 1'b0;
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            settle_q  <= '0;
            armed_q   <= 1'b0;
            wr_vld_q  <= 1'b0;
            frm_err_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            s_cs_d_q  <= s_cs;
            s_clk_d_q <= s_clk;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
            wr_vld_q  <= wr_vld_d;
            frm_err_q <= frm_err_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        armed_d   = armed_q;
        wr_vld_d  = 1'b0;
        frm_err_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // The CS synchroniser flushes its reset level after reset; a frame already in
        // progress would look like a fresh cs_fall, so accept frames only once CS is seen high.
        if (settle_q != SET_DONE) begin
            settle_d = settle_q + SET_W'(1);
        end
        if (!armed_q && (settle_q == SET_DONE) && s_cs) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall && armed_q) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = ST_RX;
                end
            end
            ST_RX: begin
                if (sclk_rise) begin
                    if (cnt_q < CNT_FULL) begin
                        shreg_d = {shreg_q[FRAME_W-2:0], s_mosi};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (cnt_q == CNT_FULL) begin
                        cnt_d = CNT_SAT;
                    end
                end
                if (cs_rise) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
                if (cnt_q == CNT_FULL) begin
                    wr_vld_d  = 1'b1;
                    wr_addr_d = shreg_q[FRAME_W-1:DATA_W];
                    wr_data_d = shreg_q[DATA_W-1:0];
                end else begin
                    frm_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign WR_VLD  = wr_vld_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;
    assign FRM_ERR = frm_err_q;
    assign BUSY    = (state_q == ST_RX);

endmodule
